// File: rtl/scalar_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : scalar_wb_arbiter
// Purpose  : Write-port controller for the scalar register file. Shares the
//            single write port between ALU and memory-load writeback
//            requesters with round-robin arbitration. rf_we/rf_rd/rf_wd are
//            registered so they are stable at the file's negedge write. An
//            optional per-register pending-write scoreboard feeds the issue
//            stage.
// Ports    : clk, rst (async, active-high)
//            alu_valid/alu_ready/alu_rd/alu_data  - ALU writeback request
//            mem_valid/mem_ready/mem_rd/mem_data  - memory-load writeback
//            issue_valid/issue_rd                 - dispatch of a new producer
//            busy                                 - per-register pending flags
//            rf_we/rf_rd/rf_wd                    - register-file write port
// Config   : SCALAR_WB_SCOREBOARD_EN - when defined, the scoreboard is built;
//            otherwise busy is tied to zero and issue_* are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module scalar_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rd,
  output logic [2**ADDR_W-1:0]   busy,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]      rf_wd
);

  localparam int                c_NREG = 2**ADDR_W;
  // Highest index is backed by an external register; writes to it are dropped.
  localparam logic [ADDR_W-1:0] c_RHI  = '1;

  typedef enum logic [0:0] {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  grant_t              r_last_grant;
  grant_t              w_last_next;
  logic                r_rf_we;
  logic [ADDR_W-1:0]   r_rf_rd;
  logic [DATA_W-1:0]   r_rf_wd;
  logic                w_we_next;
  logic [ADDR_W-1:0]   w_rd_next;
  logic [DATA_W-1:0]   w_wd_next;
  logic                w_grant_alu;
  logic                w_grant_mem;
  logic                w_hs;
  logic [ADDR_W-1:0]   w_sel_rd;
  logic [DATA_W-1:0]   w_sel_data;

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    w_grant_alu = alu_valid && (!mem_valid || (r_last_grant == GRANT_MEM));
    w_grant_mem = mem_valid && (!alu_valid || (r_last_grant == GRANT_ALU));
    // A grant implies valid, and ready equals grant, so grant is a handshake.
    w_hs        = w_grant_alu || w_grant_mem;
    w_sel_rd    = w_grant_alu ? alu_rd   : mem_rd;
    w_sel_data  = w_grant_alu ? alu_data : mem_data;
  end

  assign alu_ready = w_grant_alu;
  assign mem_ready = w_grant_mem;

  always_comb begin
    w_we_next   = 1'b0;
    w_rd_next   = r_rf_rd;
    w_wd_next   = r_rf_wd;
    w_last_next = r_last_grant;
    if (w_hs) begin
      w_rd_next   = w_sel_rd;
      w_wd_next   = w_sel_data;
      w_we_next   = (w_sel_rd != c_RHI);
      w_last_next = w_grant_alu ? GRANT_ALU : GRANT_MEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we      <= 1'b0;
      r_rf_rd      <= '0;
      r_rf_wd      <= '0;
      r_last_grant <= GRANT_MEM;
    end else begin
      r_rf_we      <= w_we_next;
      r_rf_rd      <= w_rd_next;
      r_rf_wd      <= w_wd_next;
      r_last_grant <= w_last_next;
    end
  end

  assign rf_we = r_rf_we;
  assign rf_rd = r_rf_rd;
  assign rf_wd = r_rf_wd;

`ifdef SCALAR_WB_SCOREBOARD_EN
  logic [c_NREG-1:0] r_busy;
  logic [c_NREG-1:0] w_busy_next;

  // Clear first, then set: a newer producer issued on the same edge as the
  // older write completes must keep the register pending.
  always_comb begin
    w_busy_next = r_busy;
    if (w_hs) begin
      w_busy_next[w_sel_rd] = 1'b0;
    end
    if (issue_valid) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    w_busy_next[c_NREG-1] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy = r_busy;
`else
  logic w_unused_issue;
  assign w_unused_issue = ^{issue_valid, issue_rd};
  assign busy = {c_NREG{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_scalar_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_scalar_wb_arbiter
// Purpose  : Directed self-checking bench for scalar_wb_arbiter. Models the
//            register file (negedge write) to confirm what actually lands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scalar_wb_arbiter;

`ifdef SCALAR_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [2:0]  alu_rd = '0;
  logic [15:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [2:0]  mem_rd = '0;
  logic [15:0] mem_data = '0;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_rd = '0;
  logic [7:0]  busy;
  logic        rf_we;
  logic [2:0]  rf_rd;
  logic [15:0] rf_wd;

  logic [15:0] rf_model [8];
  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  scalar_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
  );

  // Register file writes at negedge from the registered write port.
  always @(negedge clk) begin
    if (rf_we) rf_model[rf_rd] <= rf_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sbx(input logic [7:0] v);
    return SB ? v : 8'h00;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) rf_model[i] = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_rd", rf_rd, 0);
    chk("reset_rf_wd", rf_wd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_alu_ready", alu_ready, 0);
    chk("reset_mem_ready", mem_ready, 0);

    // Single ALU write to r2
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 16'h1234;
    #1;
    chk("t1_alu_ready", alu_ready, 1);
    chk("t1_mem_ready", mem_ready, 0);
    @(posedge clk); #1;
    chk("t1_rf_we", rf_we, 1);
    chk("t1_rf_rd", rf_rd, 2);
    chk("t1_rf_wd", rf_wd, 16'h1234);
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    chk("t1_rf2", rf_model[2], 16'h1234);
    @(posedge clk); #1;
    chk("t1_rf_we_drop", rf_we, 0);

    // Fresh reset so the first tie goes to ALU
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Both requesters valid for 4 cycles: ALU, MEM, ALU, MEM
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'hAAAA;
    mem_valid = 1'b1; mem_rd = 3'd3; mem_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
      chk("t2_mem_ready", mem_ready, (i % 2 == 0) ? 0 : 1);
      chk("t2_exclusive", alu_ready & mem_ready, 0);
      @(posedge clk); #1;
      chk("t2_rf_we", rf_we, 1);
      chk("t2_rf_rd", rf_rd, (i % 2 == 0) ? 1 : 3);
      chk("t2_rf_wd", rf_wd, (i % 2 == 0) ? 16'hAAAA : 16'h5555);
      @(negedge clk);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    chk("t2_rf1", rf_model[1], 16'hAAAA);
    chk("t2_rf3", rf_model[3], 16'h5555);

    // Scoreboard set by issue, cleared by the MEM write
    issue_valid = 1'b1; issue_rd = 3'd4;
    @(posedge clk); #1;
    chk("t3_busy_set", busy, sbx(8'h10));
    @(negedge clk);
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 3'd4; mem_data = 16'h0BEE;
    #1;
    chk("t3_mem_ready", mem_ready, 1);
    @(posedge clk); #1;
    chk("t3_busy_clr", busy, 8'h00);
    chk("t3_rf_we", rf_we, 1);
    chk("t3_rf_rd", rf_rd, 4);
    @(negedge clk);
    mem_valid = 1'b0;

    // Set and clear of r5 on the same edge: set wins
    issue_valid = 1'b1; issue_rd = 3'd5;
    alu_valid = 1'b1; alu_rd = 3'd5; alu_data = 16'h0055;
    @(posedge clk); #1;
    chk("t4_busy", busy, sbx(8'h20));
    chk("t4_rf_we", rf_we, 1);
    @(negedge clk);
    issue_valid = 1'b0; alu_valid = 1'b0;
    @(posedge clk); #1;
    chk("t4_busy_hold", busy, sbx(8'h20));
    chk("t4_rf_we_drop", rf_we, 0);

    // Write to r7 is accepted and discarded; issue to r7 ignored
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 3'd7; alu_data = 16'hFFFF;
    issue_valid = 1'b1; issue_rd = 3'd7;
    #1;
    chk("t5_alu_ready", alu_ready, 1);
    @(posedge clk); #1;
    chk("t5_rf_we", rf_we, 0);
    chk("t5_busy", busy, sbx(8'h20));
    @(negedge clk);
    alu_valid = 1'b0; issue_valid = 1'b0;
    #1;
    chk("t5_rf7", rf_model[7], 16'h0000);

    // Reset between a handshake edge and its negedge kills the write
    alu_valid = 1'b1; alu_rd = 3'd6; alu_data = 16'h6666;
    @(posedge clk); #1;
    chk("t6_rf_we_pre", rf_we, 1);
    rst = 1'b1;
    #1;
    chk("t6_rf_we", rf_we, 0);
    chk("t6_rf_rd", rf_rd, 0);
    chk("t6_rf_wd", rf_wd, 0);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("t6_rf6", rf_model[6], 16'h0000);
    // last_grant back at MEM: ALU wins the tie
    mem_valid = 1'b1; mem_rd = 3'd0; mem_data = 16'h0000;
    rst = 1'b0;
    #1;
    chk("t6_alu_ready", alu_ready, 1);
    chk("t6_mem_ready", mem_ready, 0);
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scalar_wb_arbiter.md
# scalar_wb_arbiter

Write-port controller for the 8×16-bit scalar register file. It shares the file's single write port between two writeback requesters, the ALU and memory-load returns, using valid/ready handshakes and round-robin arbitration. It drives registered write-enable, write-address and write-data so they are stable at the file's negedge write, and it keeps a per-register pending-write scoreboard for the issue stage.

## Interface
- DATA_W, 16, writeback data width
- ADDR_W, 3, register index width (2**ADDR_W registers)

- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid / mem_ready / mem_rd / mem_data  same as alu_*, for memory-load returns
- issue_valid  in  1  issue stage dispatches an instruction that will write issue_rd
- issue_rd  in  ADDR_W  destination of the dispatched instruction
- busy  out  2**ADDR_W  per-register pending-write flags
- rf_we  out  1  register-file write enable
- rf_rd  out  ADDR_W  register-file destination_register
- rf_wd  out  DATA_W  register-file write data

## Operation
- Arbiter state is one bit, last_grant ∈ {ALU, MEM}. It resets to MEM, so ALU wins the first tie.
- Grant is combinational from the valid signals and last_grant:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not named by last_grant is granted.
  - Neither valid: no grant.
- alu_ready and mem_ready equal their grant. At most one is high per cycle. Ready may depend on both valids.
- A handshake is valid && ready at a posedge.
- On a handshake at posedge:
  - rf_rd and rf_wd load the winner's rd and data.
  - rf_we loads 1, except when rd == 7, where it loads 0. Register 7 reads come from the external R7, so writes to index 7 are accepted and discarded.
  - last_grant updates to the winner.
- No handshake: rf_we loads 0; rf_rd, rf_wd and last_grant hold.
- Requesters must hold rd and data stable while valid && !ready. The arbiter does not buffer.
- Scoreboard:
  - busy[issue_rd] is set at the posedge where issue_valid is high.
  - busy[r] is cleared at the posedge of a handshake with rd == r.
  - Same register set and cleared in the same cycle: set wins, because a newer producer is in flight.
  - busy[7] is constant 0; an issue to register 7 is ignored.
  - Issuing to a register that is already busy keeps it busy. There is no counting: one write clears it.
- Reset mid-operation: all outputs go to their reset values immediately. An in-flight rf_we pulse is killed, so no write occurs at the following negedge.

## Timing
- Reset values: rf_we=0, rf_rd=0, rf_wd=0, busy=0, last_grant=MEM. alu_ready and mem_ready follow their combinational grant.
- Handshake at posedge N:
  - rf_we/rf_rd/rf_wd are valid from posedge N until posedge N+1.
  - The register file writes at the negedge in between, so readers see the value from that negedge.
- busy[r] falls at posedge N, the same edge the write is registered.
- Throughput is one write per cycle. With both requesters continuously valid, grants alternate ALU, MEM, ALU, …
- Worst-case wait for a valid requester is 1 cycle.

## Configuration
- SCALAR_WB_SCOREBOARD_EN defined: scoreboard is present as described.
- SCALAR_WB_SCOREBOARD_EN undefined:
  - busy is tied to all zeros.
  - issue_valid and issue_rd are ignored.
  - No scoreboard flops are generated.
  - Arbitration and write-port behaviour are unchanged.

## Test plan
- Reset, then alu_valid=1, alu_rd=2, alu_data=16'h1234 for one cycle -> alu_ready=1 that cycle. Next cycle rf_we=1, rf_rd=2, rf_wd=16'h1234. Register 2 reads 16'h1234 after that negedge.
- alu_valid and mem_valid both held high for 4 cycles, with alu_rd=1/alu_data=16'hAAAA and mem_rd=3/mem_data=16'h5555 -> grants ALU, MEM, ALU, MEM. Neither ready is ever high with the other.
- issue_valid, issue_rd=4 -> busy=8'h10 next cycle. mem_valid, mem_rd=4 handshake -> busy=8'h00 on the same edge rf_we rises.
- issue_rd=5 and a handshake with rd=5 at the same posedge -> busy[5]=1 afterwards.
- Handshake with alu_rd=7, alu_data=16'hFFFF -> alu_ready=1, rf_we stays 0, and busy[7] stays 0 even after issue_rd=7.
- Handshake at posedge N, rst pulsed high before the negedge -> rf_we=0 immediately, no register-file write, and busy/last_grant at reset values. Repeat this scenario with SCALAR_WB_SCOREBOARD_EN undefined and confirm busy stays 0 throughout.
